// File: rtl/mul_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl_pkg
// Description : Shared definitions for the iterative RV32M multiply unit.
//               Holds the op encodings, the controller state encodings, the
//               iteration count and the operand-signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_seq_ctrl_pkg;

    // RV32M multiply op encodings (in_op)
    localparam logic [1:0] MUL_OP    = 2'b00;
    localparam logic [1:0] MULH_OP   = 2'b01;
    localparam logic [1:0] MULHSU_OP = 2'b10;
    localparam logic [1:0] MULHU_OP  = 2'b11;

    // Controller state encodings
    localparam int         STATE_W = 3;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] NEG_A   = 3'd1;
    localparam logic [2:0] NEG_B   = 3'd2;
    localparam logic [2:0] MUL     = 3'd3;
    localparam logic [2:0] NEG_LO  = 3'd4;
    localparam logic [2:0] NEG_HI  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    // Number of shift-add iterations
    localparam int MUL_ITERS = 32;

    // rs1 is treated as signed for MULH and MULHSU
    function automatic logic a_signed(input logic [1:0] op);
        return (op == MULH_OP) || (op == MULHSU_OP);
    endfunction

    // rs2 is treated as signed only for MULH
    function automatic logic b_signed(input logic [1:0] op);
        return (op == MULH_OP);
    endfunction

endpackage : mul_seq_ctrl_pkg
`default_nettype wire

// File: rtl/mul_seq_ctrl_cla.sv
`default_nettype none
// ============================================================================
// Module      : LookAheadCarryAdder32
// Description : 32-bit adder built from eight 4-bit carry-lookahead groups.
//               Inside a group every carry is computed directly from the
//               generate/propagate terms; group carries chain group to group.
// Ports       : A, B  - 32-bit addends
//               Cin   - carry in
//               Sum   - 32-bit sum
//               Cout  - carry out of bit 31
// Revision    : 1.0 - initial release
// ============================================================================
module LookAheadCarryAdder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout
);

    localparam int c_GROUPS = 8;

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g    = A & B;
    assign w_p    = A ^ B;
    assign w_c[0] = Cin;

    generate
        for (genvar gi = 0; gi < c_GROUPS; gi++) begin : g_grp
            localparam int c_B = gi * 4;
            logic [3:0] w_gg;
            logic [3:0] w_pp;
            logic       w_ci;

            assign w_gg = w_g[c_B +: 4];
            assign w_pp = w_p[c_B +: 4];
            assign w_ci = w_c[c_B];

            assign w_c[c_B + 1] = w_gg[0] | (w_pp[0] & w_ci);
            assign w_c[c_B + 2] = w_gg[1] | (w_pp[1] & w_gg[0])
                                | (w_pp[1] & w_pp[0] & w_ci);
            assign w_c[c_B + 3] = w_gg[2] | (w_pp[2] & w_gg[1])
                                | (w_pp[2] & w_pp[1] & w_gg[0])
                                | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
            assign w_c[c_B + 4] = w_gg[3] | (w_pp[3] & w_gg[2])
                                | (w_pp[3] & w_pp[2] & w_gg[1])
                                | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                                | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
        end
    endgenerate

    assign Sum  = w_p ^ w_c[31:0];
    assign Cout = w_c[32];

endmodule : LookAheadCarryAdder32
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU). One
//               shared 32-bit adder is sequenced through operand negation,
//               32 shift-add steps and a 64-bit result negation.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               flush        - abort the current operation
//               in_valid/in_ready, in_op, in_a, in_b - request handshake
//               out_valid/out_ready, out_result      - result handshake
//               busy         - unit is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    generate
        if (WIDTH != 32) begin : g_bad_width
            $error("mul_seq_ctrl: WIDTH must be 32 (fixed-width adder)");
        end
    endgenerate

    // Architectural state
    logic [STATE_W-1:0] r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_neg_res;
    logic               r_cy;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_result;

    // Next-state values
    logic [STATE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         w_op_nxt;
    logic               w_neg_res_nxt;
    logic               w_cy_nxt;
    logic               w_out_valid_nxt;
    logic [WIDTH-1:0]   w_out_result_nxt;

    // Shared adder
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_cin;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_a_sgn;
    logic               w_b_sgn;

    LookAheadCarryAdder32 u_adder (
        .A    (w_add_a),
        .B    (w_add_b),
        .Cin  (w_add_cin),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    // Iteration counter has its own incrementer so the adder stays free
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_a_sgn   = a_signed(r_op);
    assign w_b_sgn   = b_signed(r_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mcand      <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_cnt        <= '0;
            r_op         <= '0;
            r_neg_res    <= 1'b0;
            r_cy         <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mcand      <= w_mcand_nxt;
            r_hi         <= w_hi_nxt;
            r_lo         <= w_lo_nxt;
            r_cnt        <= w_cnt_nxt;
            r_op         <= w_op_nxt;
            r_neg_res    <= w_neg_res_nxt;
            r_cy         <= w_cy_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_result <= w_out_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_mcand_nxt      = r_mcand;
        w_hi_nxt         = r_hi;
        w_lo_nxt         = r_lo;
        w_cnt_nxt        = r_cnt;
        w_op_nxt         = r_op;
        w_neg_res_nxt    = r_neg_res;
        w_cy_nxt         = r_cy;
        w_out_valid_nxt  = r_out_valid;
        w_out_result_nxt = r_out_result;
        w_add_a          = r_hi;
        w_add_b          = '0;
        w_add_cin        = 1'b0;

        case (r_state)
            IDLE: begin
                if (in_valid && !flush) begin
                    w_mcand_nxt   = in_a;
                    w_lo_nxt      = in_b;
                    w_hi_nxt      = '0;
                    w_op_nxt      = in_op;
                    w_neg_res_nxt = (a_signed(in_op) & in_a[WIDTH-1])
                                  ^ (b_signed(in_op) & in_b[WIDTH-1]);
                    w_cnt_nxt     = '0;
                    w_state_nxt   = NEG_A;
                end
            end
            // Two's-complement negation as ~x + 1. The state costs a cycle
            // even for unsigned operands to keep latency fixed.
            NEG_A: begin
                w_add_a   = ~r_mcand;
                w_add_cin = 1'b1;
                if (w_a_sgn && r_mcand[WIDTH-1]) begin
                    w_mcand_nxt = w_sum;
                end
                w_state_nxt = NEG_B;
            end
            NEG_B: begin
                w_add_a   = ~r_lo;
                w_add_cin = 1'b1;
                if (w_b_sgn && r_lo[WIDTH-1]) begin
                    w_lo_nxt = w_sum;
                end
                w_state_nxt = MUL;
            end
            // Shift-add: the multiplier is consumed from lo[0] while product
            // bits shift into lo from the top; the adder carry becomes the
            // new MSB of hi.
            MUL: begin
                w_add_a   = r_hi;
                w_add_b   = r_lo[0] ? r_mcand : '0;
                w_hi_nxt  = {w_cout, w_sum[WIDTH-1:1]};
                w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt == CNT_W'(MUL_ITERS - 1)) begin
                    w_state_nxt = NEG_LO;
                end
            end
            // 64-bit negation in two halves; the low-half carry feeds the
            // high half's carry in.
            NEG_LO: begin
                w_add_a   = ~r_lo;
                w_add_cin = 1'b1;
                if (r_neg_res) begin
                    w_lo_nxt = w_sum;
                    w_cy_nxt = w_cout;
                end else begin
                    w_cy_nxt = 1'b0;
                end
                w_state_nxt = NEG_HI;
            end
            NEG_HI: begin
                w_add_a   = ~r_hi;
                w_add_cin = r_cy;
                if (r_neg_res) begin
                    w_hi_nxt = w_sum;
                end
                w_state_nxt = DONE;
            end
            // First DONE cycle registers the result; it is then held until
            // the consumer takes it.
            DONE: begin
                if (r_out_valid) begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = IDLE;
                    end
                end else begin
                    w_out_valid_nxt  = 1'b1;
                    w_out_result_nxt = (r_op == MUL_OP) ? r_lo : r_hi;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (flush) begin
            w_state_nxt     = IDLE;
            w_out_valid_nxt = 1'b0;
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;

endmodule : mul_seq_ctrl
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking bench for mul_seq_ctrl. Stimulus pushes the
//               hand-computed result into a queue; a monitor pops and
//               compares whenever a result handshake occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;
    import mul_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mul_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Scoreboard monitor: a flush in the same cycle drops the result
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got=%08h expected=none", out_result);
            end else begin
                check32("result", out_result, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!in_ready && k < 100) begin
            step();
            k++;
        end
        if (!in_ready) check_int("wait_idle_timeout", 0, 1);
    endtask

    // Present one request; returns after the accepting posedge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n;
        exp_q.push_back(exp);
        issue(op, a, b);
        wait_valid(n);
        check_int({name, "_latency"}, n, 37);
        if (!out_valid) begin
            void'(exp_q.pop_back());
            flush = 1'b1;
            step();
            flush = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check32({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check32({name, "_hold_result"}, out_result, exp);
            check32({name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
            in_valid = 1'b1;
            in_op    = MUL_OP;
            in_a     = 32'd7;
            in_b     = 32'd9;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check32({name, "_idle_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;

        repeat (3) step();
        rst = 1'b0;
        check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check32("reset_out_result", out_result, 32'd0);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_in_ready", {31'b0, in_ready}, 32'd1);

        run_op("mulhu_ff",  MULHU_OP,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mul_ff",    MUL_OP,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
        run_op("mulh_min",  MULH_OP,   32'h80000000, 32'h80000000, 32'h40000000, 0);
        run_op("mul_neg3",  MUL_OP,    32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 0);
        run_op("mulh_neg3", MULH_OP,   32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 0);
        run_op("mulhsu_ff", MULHSU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("mulhsu_2",  MULHSU_OP, 32'h00000002, 32'h80000000, 32'h00000001, 0);

        // Backpressure: result held for 5 cycles while a new request waits
        run_op("backpressure", MULHU_OP, 32'h00010000, 32'h00030000, 32'h00000003, 5);

        // Flush while the iteration counter is at 10
        issue(MUL_OP, 32'd11, 32'd13);
        repeat (12) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check32("flush_mid_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        check_int("flush_mid_no_valid", seen, 0);
        run_op("mul_3x5", MUL_OP, 32'd3, 32'd5, 32'h0000000F, 0);

        // Flush in IDLE beats a simultaneous request
        in_valid = 1'b1;
        in_op    = MUL_OP;
        in_a     = 32'd2;
        in_b     = 32'd2;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check32("flush_idle_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        check_int("flush_idle_no_valid", seen, 0);

        // Reset during NEG_HI
        issue(MULHU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (35) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check32("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check32("rst_mid_out_result", out_result, 32'd0);
        check32("rst_mid_busy", {31'b0, busy}, 32'd0);

        // Flush in DONE with out_ready=1 drops the result
        issue(MUL_OP, 32'd6, 32'd7);
        wait_valid(n);
        check_int("flush_done_latency", n, 37);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        check32("flush_done_out_valid", {31'b0, out_valid}, 32'd0);
        check32("flush_done_busy", {31'b0, busy}, 32'd0);

        run_op("mul_after", MUL_OP, 32'd100, 32'd200, 32'd20000, 0);

        repeat (3) step();
        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul_seq_ctrl
`default_nettype wire
